sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Reader side of the sprite colour ROMs (mem_player_N family: async read, ADDRESS-bit address, COLOR_BITS-bit RGB word).
- On a start pulse, walks every texel of one sprite in raster order and drives the ROM address.
- Skips transparent-key texels and texels clipped off-screen.
- Writes the remaining pixels to the framebuffer writer through a valid/ready handshake.

Parameters:
- ADDRESS, 10, ROM address width; SPR_W*SPR_H must equal 1<<ADDRESS.
- COLOR_BITS, 24, RGB word width.
- SPR_W, 32, sprite width in texels (power of two).
- SPR_H, 32, sprite height in texels.
- FB_W, 640, framebuffer width.
- FB_H, 480, framebuffer height.
- X_BITS, 10, framebuffer x coordinate width.
- Y_BITS, 9, framebuffer y coordinate width.
- TRANSPARENT, 24'hFF00FF, colour key that is never written.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to blit; ignored while busy.
- pos_x  in  X_BITS  screen x of sprite top-left; sampled with start.
- pos_y  in  Y_BITS  screen y of sprite top-left; sampled with start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the blit completes.
- rom_addr  out  ADDRESS  texel address to the sprite ROM; equals row*SPR_W+col.
- rom_dout  in  COLOR_BITS  combinational ROM read data.
- fb_wr_valid  out  1  framebuffer write request.
- fb_wr_ready  in  1  framebuffer accepts the write this cycle.
- fb_wr_x  out  X_BITS  pixel x.
- fb_wr_y  out  Y_BITS  pixel y.
- fb_wr_data  out  COLOR_BITS  pixel colour.

Behaviour:
- Reset (async, active-high): state=IDLE; col, row, latched position and pixel registers=0; busy=0; done=0; fb_wr_valid=0; fb_wr_x/y/data=0; rom_addr=0.
- Reset mid-blit aborts immediately. No done pulse is produced. An in-flight write is dropped.
- States: IDLE, FETCH, WRITE, DONE.
- IDLE:
  - start=1 latches pos_x/pos_y and clears col and row.
  - Next state FETCH.
- FETCH:
  - rom_addr is driven from the counters.
  - At the edge, rom_dout is registered into fb_wr_data.
  - sx = pos_x+col and sy = pos_y+row are computed in X_BITS+1 / Y_BITS+1 bits, so there is no wrap, and registered into fb_wr_x/y.
  - If rom_dout==TRANSPARENT, or sx>=FB_W, or sy>=FB_H: the pixel is skipped. Counters advance and the state stays FETCH, or goes to DONE after the last texel.
  - Otherwise next state is WRITE.
- WRITE:
  - fb_wr_valid=1; x, y and data are held stable until accepted.
  - On an edge with fb_wr_ready=1, counters advance. Next state is FETCH, or DONE after the last texel.
  - fb_wr_valid never drops without acceptance.
- Advance:
  - col+1; at col==SPR_W-1, col wraps to 0 and row increments.
  - The last texel is row==SPR_H-1, col==SPR_W-1.
- DONE: done=1 for exactly one cycle, then IDLE. busy is still 1 during DONE.
- start while busy (including DONE) is ignored. There is no queueing.
- Timing, with start sampled at edge E0:
  - busy=1 after E0.
  - The first opaque pixel gives fb_wr_valid=1 after E1.
- Throughput, with fb_wr_ready tied high:
  - 2 cycles per written texel and 1 cycle per skipped texel.
  - Full opaque 32x32 sprite: DONE entered 2048 cycles after E0.
- Deasserting ready stretches WRITE indefinitely with no data change.

Decomposition:
- Shared package sprite_pkg holds:
  - state enum blit_state_t (IDLE, FETCH, WRITE, DONE);
  - TRANSPARENT_KEY;
  - FB_W and FB_H defaults;
  - the colour typedef rgb_t (logic [23:0]).
- One sub-module, sprite_addr_counter: col/row counters with clear, advance and last-texel flag. It also forms rom_addr.
- The top level keeps the FSM, clipping and handshake registers.

Test Plan:
- Opaque sprite with all texels 24'h123456, pos=(100,50), ready=1:
  - 1024 writes in raster order.
  - First write x=100,y=50; last write x=131,y=81.
  - done pulses once; DONE entered 2048 cycles after start.
- ROM with texel 0 = 24'hFF00FF and texel 5 = 24'hFF00FF, rest opaque:
  - exactly 1022 writes;
  - no write at (pos_x+0,pos_y) or (pos_x+5,pos_y).
- pos=(620,470):
  - only texels with col<20 and row<10 are written (200 writes);
  - no coordinate >= 640/480 appears.
- Backpressure:
  - ready low for 7 cycles while valid=1, fb_wr_x/y/data held constant; write completes when ready rises.
  - Total write count stays 1024.
- start pulsed again during busy: ignored, no second blit. start after done: a new blit at the new position.
- reset asserted mid-WRITE, asynchronously between edges:
  - valid, busy and done go 0 at once;
  - no done pulse;
  - the next start blits from texel 0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite blitter and its helpers.
package sprite_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} blit_state_t;

  typedef logic [23:0] rgb_t;

  localparam rgb_t TRANSPARENT_KEY = 24'hFF00FF;

  localparam int unsigned DEFAULT_FB_W = 640;
  localparam int unsigned DEFAULT_FB_H = 480;

endpackage

// File: rtl/sprite_blitter_if.sv
// Sprite ROM read port plus the framebuffer write handshake.
interface sprite_blitter_if #(
  parameter int unsigned ADDRESS    = 10,
  parameter int unsigned COLOR_BITS = 24,
  parameter int unsigned X_BITS     = 10,
  parameter int unsigned Y_BITS     = 9
) ();

  logic [ADDRESS-1:0]    rom_addr;
  logic [COLOR_BITS-1:0] rom_dout;
  logic                  fb_wr_valid;
  logic                  fb_wr_ready;
  logic [X_BITS-1:0]     fb_wr_x;
  logic [Y_BITS-1:0]     fb_wr_y;
  logic [COLOR_BITS-1:0] fb_wr_data;

  modport master (
    output rom_addr,
    input  rom_dout,
    output fb_wr_valid,
    input  fb_wr_ready,
    output fb_wr_x,
    output fb_wr_y,
    output fb_wr_data
  );

  modport slave (
    input  rom_addr,
    output rom_dout,
    input  fb_wr_valid,
    output fb_wr_ready,
    input  fb_wr_x,
    input  fb_wr_y,
    input  fb_wr_data
  );

endinterface

// File: rtl/sprite_addr_counter.sv
// Raster-order texel counter: col/row with clear, advance and a last-texel flag.
module sprite_addr_counter #(
  parameter int unsigned ADDRESS = 10,
  parameter int unsigned SPR_W   = 32,
  parameter int unsigned SPR_H   = 32,
  localparam int unsigned CW     = $clog2(SPR_W),
  localparam int unsigned RW     = ADDRESS - CW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               advance,
  output logic [CW-1:0]      col,
  output logic [RW-1:0]      row,
  output logic               last,
  output logic [ADDRESS-1:0] rom_addr
);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          col_end;

  assign col_end = (col_q == CW'(SPR_W - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (clear) begin
      col_q <= '0;
      row_q <= '0;
    end else if (advance) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = col_end && (row_q == RW'(SPR_H - 1));
  // SPR_W is a power of two, so row*SPR_W+col is a plain concatenation.
  assign rom_addr = {row_q, col_q};

endmodule

// File: rtl/sprite_blitter.sv
// Walks one sprite's texels, drops transparent/off-screen ones and writes the rest to the framebuffer.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int unsigned            ADDRESS     = 10,
  parameter int unsigned            COLOR_BITS  = 24,
  parameter int unsigned            SPR_W       = 32,
  parameter int unsigned            SPR_H       = 32,
  parameter int unsigned            FB_W        = DEFAULT_FB_W,
  parameter int unsigned            FB_H        = DEFAULT_FB_H,
  parameter int unsigned            X_BITS      = 10,
  parameter int unsigned            Y_BITS      = 9,
  parameter logic [COLOR_BITS-1:0]  TRANSPARENT = TRANSPARENT_KEY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [X_BITS-1:0] pos_x,
  input  logic [Y_BITS-1:0] pos_y,
  output logic              busy,
  output logic              done,
  sprite_blitter_if.master  bus
);

  localparam int unsigned CW = $clog2(SPR_W);
  localparam int unsigned RW = ADDRESS - CW;

  blit_state_t           state_q;
  logic [X_BITS-1:0]     px_q;
  logic [Y_BITS-1:0]     py_q;
  logic                  valid_q;
  logic [X_BITS-1:0]     x_q;
  logic [Y_BITS-1:0]     y_q;
  logic [COLOR_BITS-1:0] data_q;
  logic                  busy_q;
  logic                  done_q;

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  last;
  logic                  clear;
  logic                  advance;
  logic [X_BITS:0]       sx;
  logic [Y_BITS:0]       sy;
  logic                  skip;

  // One extra bit so a sprite hanging past the right/bottom edge never wraps on-screen.
  assign sx   = {1'b0, px_q} + (X_BITS + 1)'(col);
  assign sy   = {1'b0, py_q} + (Y_BITS + 1)'(row);
  assign skip = (bus.rom_dout == TRANSPARENT) || (sx >= (X_BITS + 1)'(FB_W)) ||
                (sy >= (Y_BITS + 1)'(FB_H));

  assign clear   = (state_q == IDLE) && start;
  assign advance = ((state_q == FETCH) && skip) || ((state_q == WRITE) && bus.fb_wr_ready);

  sprite_addr_counter #(
    .ADDRESS (ADDRESS),
    .SPR_W   (SPR_W),
    .SPR_H   (SPR_H)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .advance  (advance),
    .col      (col),
    .row      (row),
    .last     (last),
    .rom_addr (bus.rom_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      px_q    <= '0;
      py_q    <= '0;
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            px_q    <= pos_x;
            py_q    <= pos_y;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          data_q <= bus.rom_dout;
          x_q    <= sx[X_BITS-1:0];
          y_q    <= sy[Y_BITS-1:0];
          if (!skip) begin
            valid_q <= 1'b1;
            state_q <= WRITE;
          end else if (last) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        WRITE: begin
          if (bus.fb_wr_ready) begin
            valid_q <= 1'b0;
            if (last) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign bus.fb_wr_valid = valid_q;
  assign bus.fb_wr_x     = x_q;
  assign bus.fb_wr_y     = y_q;
  assign bus.fb_wr_data  = data_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomised bench for sprite_blitter against a raster-order reference model.
module tb_sprite_blitter;

  localparam logic [23:0] KEY = 24'hFF00FF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] pos_x = '0;
  logic [8:0] pos_y = '0;
  logic       busy;
  logic       done;

  logic [23:0] rom [1024];

  sprite_blitter_if #(.ADDRESS(10), .COLOR_BITS(24), .X_BITS(10), .Y_BITS(9)) bus ();

  sprite_blitter dut (
    .clk   (clk),
    .reset (rst),
    .start (start),
    .pos_x (pos_x),
    .pos_y (pos_y),
    .busy  (busy),
    .done  (done),
    .bus   (bus.master)
  );

  assign bus.rom_dout = rom[bus.rom_addr];

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor / ready driver, all on the falling edge.
  logic [42:0] cap[$];
  logic [42:0] exp_q[$];
  logic [42:0] prev_pix;
  logic        prev_valid = 1'b0;
  logic        prev_acc = 1'b0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          ready_mode = 0;
  int          stall = 0;

  always @(negedge clk) begin
    logic [42:0] pix;
    logic        rdy;
    logic        acc;
    cyc++;
    pix = {bus.fb_wr_x, bus.fb_wr_y, bus.fb_wr_data};
    if (rst) begin
      prev_valid = 1'b0;
      prev_acc   = 1'b0;
      bus.fb_wr_ready = 1'b0;
    end else begin
      if (prev_valid && !prev_acc)
        check("hold", {bus.fb_wr_valid, pix}, {1'b1, prev_pix});
      rdy = 1'b1;
      if (ready_mode == 1) begin
        if (stall > 0) begin
          rdy = 1'b0;
          stall--;
        end else if (bus.fb_wr_valid && ($urandom % 8 == 0)) begin
          rdy = 1'b0;
          stall = 6;
        end else begin
          rdy = ($urandom % 4) != 0;
        end
      end else if (ready_mode == 2) begin
        rdy = 1'b0;
      end
      bus.fb_wr_ready = rdy;
      acc = bus.fb_wr_valid && rdy;
      if (acc) cap.push_back(pix);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_valid = bus.fb_wr_valid;
      prev_acc   = acc;
      prev_pix   = pix;
    end
  end

  // Reference: every texel in raster order, kept if opaque and on-screen.
  task automatic build_exp(input int px, input int py, output int skips);
    exp_q.delete();
    skips = 0;
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        int x;
        int y;
        logic [23:0] d;
        x = px + c;
        y = py + r;
        d = rom[r * 32 + c];
        if (d != KEY && x < 640 && y < 480) begin
          logic [9:0] xv;
          logic [8:0] yv;
          xv = 10'(x);
          yv = 9'(y);
          exp_q.push_back({xv, yv, d});
        end else begin
          skips++;
        end
      end
    end
  endtask

  task automatic fill_const(input logic [23:0] v);
    for (int i = 0; i < 1024; i++) rom[i] = v;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom % 10 == 0) ? KEY : 24'($urandom);
  endtask

  task automatic run_blit(input int px, input int py, input int rmode, input bit restart);
    int skips;
    int s_cyc;
    int b0;
    bit t0;
    build_exp(px, py, skips);
    t0 = (rom[0] != KEY) && (px < 640) && (py < 480);
    ready_mode = rmode;
    cap.delete();
    done_cnt = 0;
    @(negedge clk);
    #1;
    start = 1'b1;
    pos_x = 10'(px);
    pos_y = 9'(py);
    s_cyc = cyc;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("no_valid_in_fetch", bus.fb_wr_valid, 0);
    #1 start = 1'b0;
    @(negedge clk);
    if (rmode == 0) check("first_valid", bus.fb_wr_valid, t0);
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (restart && n == 20) begin
        #1;
        start = 1'b1;
        pos_x = 10'd300;
        pos_y = 9'd300;
      end else if (restart && n == 21) begin
        #1 start = 1'b0;
      end
      if (!busy) break;
    end
    check("blit_timeout", busy, 0);
    repeat (3) @(negedge clk);
    check("busy_stays_low", busy, 0);
    check("write_count", cap.size(), exp_q.size());
    b0 = bad;
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      check("pixel", cap[i], exp_q[i]);
      if (bad != b0) break;
    end
    check("done_pulses", done_cnt, 1);
    if (rmode == 0) check("latency", done_cyc - s_cyc, 2 * exp_q.size() + skips + 1);
  endtask

  initial begin
    int dc;
    int n;
    fill_const(24'h123456);
    bus.fb_wr_ready = 1'b0;
    #23;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", bus.fb_wr_valid, 0);
    check("rst_x", bus.fb_wr_x, 0);
    check("rst_y", bus.fb_wr_y, 0);
    check("rst_data", bus.fb_wr_data, 0);
    check("rst_addr", bus.rom_addr, 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Full opaque sprite; DONE 2048 edges after start.
    run_blit(100, 50, 0, 1'b0);
    check("opaque_count", cap.size(), 1024);
    if (cap.size() == 1024) begin
      check("first_xy", cap[0][42:24], {10'd100, 9'd50});
      check("last_xy", cap[1023][42:24], {10'd131, 9'd81});
    end

    // Transparent texels 0 and 5.
    rom[0] = KEY;
    rom[5] = KEY;
    run_blit(40, 60, 0, 1'b0);
    check("key_count", cap.size(), 1022);

    // Clipping at the bottom-right corner.
    fill_const(24'h00A0B0);
    run_blit(620, 470, 0, 1'b0);
    check("clip_count", cap.size(), 200);

    // Backpressure with 7-cycle stalls.
    fill_const(24'h123456);
    run_blit(100, 50, 1, 1'b0);
    check("bp_count", cap.size(), 1024);

    // Restart during busy is ignored; next start goes to a new position.
    fill_random();
    run_blit(200, 100, 0, 1'b1);
    run_blit(5, 7, 0, 1'b0);

    // Asynchronous reset in the middle of a stalled write.
    fill_const(24'h0F0F0F);
    ready_mode = 2;
    @(negedge clk);
    #1;
    start = 1'b1;
    pos_x = 10'd10;
    pos_y = 9'd10;
    @(negedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!bus.fb_wr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_valid_seen", bus.fb_wr_valid, 1);
    repeat (3) @(negedge clk);
    dc = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("abort_valid", bus.fb_wr_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    ready_mode = 0;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt, dc);
    check("abort_idle", busy, 0);
    run_blit(10, 10, 0, 1'b0);

    // Random sprites, positions and ready patterns.
    for (int k = 0; k < 5; k++) begin
      int m;
      fill_random();
      m = $urandom % 2;
      run_blit($urandom_range(0, 700), $urandom_range(0, 500), m, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
